// File: rtl/maze_pkg.sv
// Shared maze definitions: prober state encoding, probe direction order and cell encoding.
// Also used by the solver FSM.
package maze_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_SAMPLE,
    ST_WRITE,
    ST_DONE
  } state_e;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  localparam logic CELL_WALL = 1'b1;
  localparam logic CELL_FREE = 1'b0;

endpackage

// File: rtl/maze_neighbor_addr.sv
// Combinational neighbour address for one probe direction, plus a flag saying whether that
// neighbour lies inside the N x N maze. The flag is also cleared when the centre cell itself is off the maze.
module maze_neighbor_addr
  import maze_pkg::*;
#(
  parameter int N = 16,
  parameter int B = 4
) (
  input  logic [B-1:0] cur_x,
  input  logic [B-1:0] cur_y,
  input  logic [1:0]   dir,
  output logic [B-1:0] nx,
  output logic [B-1:0] ny,
  output logic         in_bounds
);

  // One extra bit so that N = 2^B can be represented.
  localparam logic [B:0] N_LIM  = (B+1)'(N);
  localparam logic [B:0] N_LAST = (B+1)'(N - 1);

  logic cur_ok;
  logic dir_ok;

  always_comb begin
    cur_ok = ({1'b0, cur_x} < N_LIM) && ({1'b0, cur_y} < N_LIM);
    nx     = cur_x;
    ny     = cur_y;
    dir_ok = 1'b0;
    case (dir)
      DIR_UP: begin
        nx     = cur_x - 1'b1;
        dir_ok = (cur_x != '0);
      end
      DIR_RIGHT: begin
        ny     = cur_y + 1'b1;
        dir_ok = ({1'b0, cur_y} != N_LAST);
      end
      DIR_DOWN: begin
        nx     = cur_x + 1'b1;
        dir_ok = ({1'b0, cur_x} != N_LAST);
      end
      default: begin
        ny     = cur_y - 1'b1;
        dir_ok = (cur_y != '0);
      end
    endcase
    in_bounds = dir_ok && cur_ok;
  end

endmodule

// File: rtl/maze_neighbor_prober.sv
// Maze memory initiator. It probes the four neighbours of a cell and returns an open-direction mask,
// or it writes one cell. Every memory pin is driven straight from a flop.
module maze_neighbor_prober
  import maze_pkg::*;
#(
  parameter int N = 16,
  parameter int B = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         op,
  input  logic [B-1:0] cur_x,
  input  logic [B-1:0] cur_y,
  input  logic         mark_val,
  output logic         busy,
  output logic         done,
  output logic [3:0]   open_mask,
  output logic         mem_read,
  output logic         mem_write,
  output logic [B-1:0] mem_x,
  output logic [B-1:0] mem_y,
  output logic         mem_din,
  input  logic         mem_dout
);

  localparam logic [B:0] N_LIM = (B+1)'(N);

  state_e       state_q, state_d;
  logic [1:0]   dir_q, dir_d;
  logic [B-1:0] cx_q, cx_d, cy_q, cy_d;
  logic         inb_q, inb_d;
  logic [3:0]   mask_q, mask_d;
  logic         busy_q, busy_d, done_q, done_d;
  logic         rd_q, rd_d, wr_q, wr_d, din_q, din_d;
  logic [B-1:0] mx_q, mx_d, my_q, my_d;

  logic [B-1:0] a_x, a_y, nb_x, nb_y;
  logic [1:0]   a_dir;
  logic         nb_inb;
  logic         in_ok;

  // The next read address is registered on the same edge that raises mem_read. It is computed
  // from the live inputs while idle and from the latched cell once a probe is running.
  assign a_x   = (state_q == ST_IDLE) ? cur_x  : cx_q;
  assign a_y   = (state_q == ST_IDLE) ? cur_y  : cy_q;
  assign a_dir = (state_q == ST_IDLE) ? DIR_UP : dir_q + 2'd1;
  assign in_ok = ({1'b0, cur_x} < N_LIM) && ({1'b0, cur_y} < N_LIM);

  maze_neighbor_addr #(
    .N(N),
    .B(B)
  ) u_addr (
    .cur_x    (a_x),
    .cur_y    (a_y),
    .dir      (a_dir),
    .nx       (nb_x),
    .ny       (nb_y),
    .in_bounds(nb_inb)
  );

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    inb_d   = inb_q;
    mask_d  = mask_q;
    done_d  = 1'b0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    din_d   = din_q;
    mx_d    = mx_q;
    my_d    = my_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cx_d = cur_x;
          cy_d = cur_y;
          if (!op) begin
            state_d = ST_READ;
            dir_d   = DIR_UP;
            mask_d  = '0;
            inb_d   = nb_inb;
            rd_d    = nb_inb;
            mx_d    = nb_x;
            my_d    = nb_y;
          end else begin
            state_d = ST_WRITE;
            wr_d    = in_ok;
            mx_d    = cur_x;
            my_d    = cur_y;
            din_d   = mark_val;
          end
        end
      end
      ST_READ: state_d = ST_SAMPLE;
      ST_SAMPLE: begin
        mask_d[dir_q] = inb_q && (mem_dout == CELL_FREE);
        if (dir_q == DIR_LEFT) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_READ;
          dir_d   = dir_q + 2'd1;
          inb_d   = nb_inb;
          rd_d    = nb_inb;
          mx_d    = nb_x;
          my_d    = nb_y;
        end
      end
      ST_WRITE: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dir_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      inb_q   <= 1'b0;
      mask_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      din_q   <= 1'b0;
      mx_q    <= '0;
      my_q    <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      inb_q   <= inb_d;
      mask_q  <= mask_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      din_q   <= din_d;
      mx_q    <= mx_d;
      my_q    <= my_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign open_mask = mask_q;
  assign mem_read  = rd_q;
  assign mem_write = wr_q;
  assign mem_x     = mx_q;
  assign mem_y     = my_q;
  assign mem_din   = din_q;

endmodule

// File: tb/tb_maze_neighbor_prober.sv
// Scoreboard bench for maze_neighbor_prober with two instances, N=16 and N=10,
// each attached to a behavioural maze memory.
module tb_maze_neighbor_prober;
  import maze_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] start = '0, op = '0, mark = '0;
  logic [3:0] cx [2] = '{4'd0, 4'd0};
  logic [3:0] cy [2] = '{4'd0, 4'd0};
  logic [1:0] busy, done, mem_read, mem_write, mem_din, mem_dout;
  logic [3:0] open_mask [2];
  logic [3:0] mem_x [2];
  logic [3:0] mem_y [2];

  always #5 clk = ~clk;

  maze_neighbor_prober #(.N(16), .B(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .op(op[0]), .cur_x(cx[0]), .cur_y(cy[0]),
    .mark_val(mark[0]), .busy(busy[0]), .done(done[0]), .open_mask(open_mask[0]),
    .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_x(mem_x[0]), .mem_y(mem_y[0]),
    .mem_din(mem_din[0]), .mem_dout(mem_dout[0])
  );

  maze_neighbor_prober #(.N(10), .B(4)) u_dut10 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .op(op[1]), .cur_x(cx[1]), .cur_y(cy[1]),
    .mark_val(mark[1]), .busy(busy[1]), .done(done[1]), .open_mask(open_mask[1]),
    .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_x(mem_x[1]), .mem_y(mem_y[1]),
    .mem_din(mem_din[1]), .mem_dout(mem_dout[1])
  );

  // smem is the memory the DUTs see. refm is the bench's own view, used for expected masks.
  bit smem [2][16][16];
  bit refm [2][16][16];
  logic ld_en = 1'b0;
  int ld_d = 0;
  logic [3:0] ld_x = '0, ld_y = '0;
  logic ld_v = 1'b0;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_read[d]) mem_dout[d] <= smem[d][mem_x[d]][mem_y[d]];
      if (mem_write[d]) smem[d][mem_x[d]][mem_y[d]] <= mem_din[d];
    end
    if (ld_en) smem[ld_d][ld_x][ld_y] <= ld_v;
  end

  typedef struct { int d; logic [3:0] x; logic [3:0] y; logic v; } acc_t;
  typedef struct { int d; logic [3:0] mask; int cyc; } fin_t;
  acc_t rq[$];
  acc_t wq[$];
  fin_t fq[$];

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] last_mask [2] = '{4'd0, 4'd0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    acc_t a;
    fin_t f;
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (mem_read[d] || mem_write[d])
          check_eq("rw_excl", 32'(mem_read[d] & mem_write[d]), 32'd0);
        if (mem_read[d]) begin
          if (rq.size() != 0) a = rq.pop_front();
          else a = '{d: -1, x: 4'hF, y: 4'hF, v: 1'b0};
          check_eq("rd_addr", {24'(d), mem_x[d], mem_y[d]}, {24'(a.d), a.x, a.y});
        end
        if (mem_write[d]) begin
          if (wq.size() != 0) a = wq.pop_front();
          else a = '{d: -1, x: 4'hF, y: 4'hF, v: 1'b0};
          check_eq("wr_access", {23'(d), mem_x[d], mem_y[d], mem_din[d]},
                   {23'(a.d), a.x, a.y, a.v});
        end
        if (done[d]) begin
          if (fq.size() != 0) f = fq.pop_front();
          else f = '{d: -1, mask: 4'h0, cyc: -1};
          check_eq("done_dut", 32'(d), 32'(f.d));
          check_eq("done_cyc", 32'(cyc), 32'(f.cyc));
          check_eq("open_mask", 32'(open_mask[d]), 32'(f.mask));
          check_eq("busy_in_done", 32'(busy[d]), 32'd1);
        end
      end
    end
  end

  task automatic set_cell(input int d, input int x, input int y, input logic v);
    ld_d = d; ld_x = 4'(x); ld_y = 4'(y); ld_v = v; ld_en = 1'b1;
    @(posedge clk);
    #1 ld_en = 1'b0;
    refm[d][x][y] = v;
  endtask

  // Called on a negedge. Pushes the expected accesses and the completion, then drives a one-cycle start.
  task automatic issue(input int d, input logic o, input int x, input int y, input logic m);
    int n;
    int nx, ny;
    logic ok, inb;
    logic [3:0] msk;
    n = (d == 0) ? 16 : 10;
    ok = (x < n) && (y < n);
    if (!o) begin
      msk = '0;
      for (int k = 0; k < 4; k++) begin
        nx = x; ny = y;
        case (k)
          0: begin nx = x - 1; inb = (x > 0); end
          1: begin ny = y + 1; inb = (y < n - 1); end
          2: begin nx = x + 1; inb = (x < n - 1); end
          default: begin ny = y - 1; inb = (y > 0); end
        endcase
        inb = inb && ok;
        if (inb) begin
          rq.push_back('{d: d, x: 4'(nx), y: 4'(ny), v: 1'b0});
          msk[k] = (refm[d][nx][ny] == CELL_FREE);
        end
      end
      last_mask[d] = msk;
    end else if (ok) begin
      wq.push_back('{d: d, x: 4'(x), y: 4'(y), v: m});
      refm[d][x][y] = m;
    end
    fq.push_back('{d: d, mask: last_mask[d], cyc: cyc + (o ? 2 : 9)});
    op[d] = o; cx[d] = 4'(x); cy[d] = 4'(y); mark[d] = m; start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
  endtask

  task automatic wait_fin();
    int t = 0;
    while (fq.size() != 0 && t < 40) begin
      @(negedge clk);
      #1;
      t++;
    end
    check_eq("fin_timeout", 32'(fq.size()), 32'd0);
  endtask

  task automatic check_reset(input int d);
    check_eq("rst_busy", 32'(busy[d]), 32'd0);
    check_eq("rst_done", 32'(done[d]), 32'd0);
    check_eq("rst_mask", 32'(open_mask[d]), 32'd0);
    check_eq("rst_rd", 32'(mem_read[d]), 32'd0);
    check_eq("rst_wr", 32'(mem_write[d]), 32'd0);
    check_eq("rst_addr", 32'({mem_x[d], mem_y[d]}), 32'd0);
    check_eq("rst_din", 32'(mem_din[d]), 32'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    set_cell(0, 4, 7, CELL_WALL);
    set_cell(0, 1, 0, CELL_WALL);
    @(negedge clk);
    check_reset(0);
    check_reset(1);
    rst_n = 1'b1;
    @(negedge clk);

    issue(0, 1'b0, 5, 7, 1'b0);
    wait_fin();
    check_eq("mask_5_7", 32'(open_mask[0]), 32'b1110);

    @(negedge clk);
    issue(0, 1'b0, 0, 0, 1'b0);
    wait_fin();
    check_eq("mask_0_0", 32'(open_mask[0]), 32'b0010);

    @(negedge clk);
    issue(0, 1'b1, 3, 3, 1'b1);
    wait_fin();
    check_eq("mask_kept_by_write", 32'(open_mask[0]), 32'b0010);
    @(negedge clk);
    issue(0, 1'b0, 3, 4, 1'b0);
    wait_fin();
    check_eq("mask_3_4_left", 32'(open_mask[0][3]), 32'd0);
    check_eq("mask_3_4", 32'(open_mask[0]), 32'b0111);

    // Write commands raised while busy must leave no trace.
    @(negedge clk);
    issue(0, 1'b0, 8, 8, 1'b0);
    for (int i = 0; i < 3; i++) begin
      op[0] = 1'b1; cx[0] = 4'd2; cy[0] = 4'd2; mark[0] = 1'b1; start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      @(negedge clk);
    end
    wait_fin();
    @(negedge clk);
    issue(0, 1'b0, 5, 7, 1'b0);
    wait_fin();
    check_eq("ignored_write_cell", 32'(smem[0][2][2]), 32'd0);

    // Reset in the 4th cycle after the accepting edge.
    @(negedge clk);
    issue(0, 1'b0, 5, 7, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("busy_mid_probe", 32'(busy[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset(0);
    rq.delete();
    fq.delete();
    last_mask[0] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(0, 1'b0, 0, 0, 1'b0);
    wait_fin();
    check_eq("mask_after_reset", 32'(open_mask[0]), 32'b0010);

    @(negedge clk);
    issue(1, 1'b0, 9, 9, 1'b0);
    wait_fin();
    check_eq("n10_mask_9_9_rd", 32'(open_mask[1][2:1]), 32'd0);
    check_eq("n10_mask_9_9", 32'(open_mask[1]), 32'b1001);
    @(negedge clk);
    issue(1, 1'b0, 12, 3, 1'b0);
    wait_fin();
    check_eq("n10_mask_12_3", 32'(open_mask[1]), 32'd0);

    repeat (3) @(negedge clk);
    check_eq("reads_pending", 32'(rq.size()), 32'd0);
    check_eq("writes_pending", 32'(wq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/maze_neighbor_prober.md
# maze_neighbor_prober

Memory-side initiator for the maze cell memory (1-bit cells, X = row, Y = column, 1 = wall, 0 = free). On a start command it either probes the four orthogonal neighbours of a cell and returns an open-direction mask, or writes one cell (mark visited/wall). It sits between the maze-solver control FSM and the maze memory. It is the only block that drives the memory's Read/Write/X/Y/D_in pins.

## Interface
- N, 16, maze dimension (N×N cells), 2..2^B
- B, 4, coordinate width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  command request; sampled only in IDLE
- op  in  1  0 = probe neighbours, 1 = write cell
- cur_x, cur_y  in  B  target cell (row, column)
- mark_val  in  1  data for write op
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle completion pulse
- open_mask  out  4  bit0 up (X-1), bit1 right (Y+1), bit2 down (X+1), bit3 left (Y-1); 1 = in-bounds and free
- mem_read, mem_write  out  1  memory strobes
- mem_x, mem_y  out  B  memory address
- mem_din  out  1  memory write data
- mem_dout  in  1  memory read data (memory registers it on the clk edge where Read is high)

## Operation
- States: IDLE, READ, SAMPLE, WRITE, DONE. A 2-bit direction counter `dir` is used in the order up, right, down, left.
- IDLE: when start = 1, latch op, cur_x, cur_y and mark_val. Go to READ with dir = 0 (op = 0), or to WRITE (op = 1). start while busy is ignored, with no queueing.
- READ: drive mem_x/mem_y to the neighbour of dir. Set mem_read = 1 only if that neighbour is in bounds.
  - Out of bounds: up when X = 0, right when Y = N-1, down when X = N-1, left when Y = 0.
  - Always go to SAMPLE.
- SAMPLE: mem_read = 0. At the ending edge, open_mask[dir] <= in_bounds && (mem_dout == 0). If dir = 3, go to DONE; otherwise dir + 1 and go to READ.
- WRITE: mem_write = 1, mem_x/mem_y = cur, mem_din = mark_val. Go to DONE.
- DONE: done = 1. Go to IDLE.
- If the latched cur_x or cur_y is ≥ N: issue no memory strobes, force open_mask to 0, keep the normal latency.
- open_mask is cleared at probe start and holds its value until the next probe start. A write op leaves it unchanged.
- Neighbour address arithmetic is B-bit. Out-of-bounds addresses are never strobed, so wrapped values are don't-care.
- All memory outputs come directly from flops: glitch-free, with the address changing on the same edge that raises mem_read. This is required because the memory is also sensitive to the rising edge of Read.
- mem_read and mem_write are never high together.

## Timing
- Reset values: busy 0, done 0, open_mask 0, mem_read 0, mem_write 0, mem_x 0, mem_y 0, mem_din 0, state IDLE. They apply asynchronously the moment rst_n falls, including mid-command. No partial command resumes after reset.
- Let E0 be the edge that accepts start.
- Probe: READ/SAMPLE pairs occupy E0–E8. done is high between E8 and E9. Latency is fixed at 9 cycles regardless of bounds.
- Read data: mem_read is high for the cycle after E(2k). The memory updates mem_dout at E(2k+1). The prober captures it at E(2k+2).
- Write: mem_write is high between E0 and E1, and the memory commits at E1. done is high between E1 and E2.
- A new start is accepted in the cycle after done, i.e. back-to-back with one cycle of IDLE.

## Structure
- Package maze_pkg: state enum, direction constants (DIR_UP = 0, DIR_RIGHT = 1, DIR_DOWN = 2, DIR_LEFT = 3), and cell encoding CELL_WALL = 1 / CELL_FREE = 0, shared with the solver FSM.
- One natural sub-module: maze_neighbor_addr, combinational. Inputs are (cur_x, cur_y, dir); outputs are (nx, ny, in_bounds), parameterised by N and B.

## Test plan
- Reset: assert rst_n = 0 mid-probe, in the 4th cycle after E0 → all outputs 0 immediately. A fresh probe after release returns the correct mask.
- Interior probe, N = 16, cur (5,7), with wall at (4,7) and free cells at (5,8), (6,7), (5,6):
  - reads occur in order at (4,7), (5,8), (6,7), (5,6);
  - open_mask = 4'b1110;
  - done is high exactly between E8 and E9.
- Corner probe at (0,0), with (0,1) free and (1,0) wall:
  - exactly 2 mem_read pulses, at (0,1) then (1,0);
  - open_mask = 4'b0010;
  - done still at E8.
- Write then probe: write (3,3) with mark_val = 1 → mem_write is high for one cycle with addr (3,3) and done after E1. Then probe (3,4) → open_mask[3] = 0.
- start pulses during busy (op = 1, other coordinates) → ignored, with no extra strobes. Back-to-back start right after done is accepted.
- Parameter N = 10, B = 4:
  - probe at (9,9) → right and down are never strobed, open_mask[2:1] = 0;
  - probe at (12,3) → no strobes, open_mask = 0, done at E8.
